sys_seg_display: RTL



---
 rtl/sys_seg_display.sv | 103 ++++++++++
 1 files changed

// File: rtl/sys_seg_display.sv
// Eight-digit common-anode hex display for the 27-bit debug bus.
// The shadow word reloads only at frame boundaries, so a scan never shows two different words.
module sys_seg_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic [26:0] SYS_leds,
    input  logic [7:0]  SYS_output_sel,
    input  logic        DISP_hold,
    input  logic        DISP_blank_lz,
    output logic [7:0]  SEG_an,
    output logic [6:0]  SEG_cat,
    output logic        SEG_dp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic [26:0]      sh;
    logic [3:0]       ss;
    logic             div_last;
    logic [3:0]       nib [8];
    logic [7:0]       lz_blank;
    logic             zero_run;
    logic [6:0]       cur_cat;

    // Only the low nibble of the select is displayed.
    logic unused_sel;
    assign unused_sel = ^SYS_output_sel[7:4];

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0:    f = 7'b1000000;
            4'h1:    f = 7'b1111001;
            4'h2:    f = 7'b0100100;
            4'h3:    f = 7'b0110000;
            4'h4:    f = 7'b0011001;
            4'h5:    f = 7'b0010010;
            4'h6:    f = 7'b0000010;
            4'h7:    f = 7'b1111000;
            4'h8:    f = 7'b0000000;
            4'h9:    f = 7'b0010000;
            4'hA:    f = 7'b0001000;
            4'hB:    f = 7'b0000011;
            4'hC:    f = 7'b1000110;
            4'hD:    f = 7'b0100001;
            4'hE:    f = 7'b0000110;
            default: f = 7'b0001110;
        endcase
        return f;
    endfunction

    assign div_last = (div == DIV_LAST);

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            nib[k] = sh[4*k +: 4];
        end
        nib[6] = {1'b0, sh[26:24]};
        nib[7] = ss;

        // Walk down from digit 6; a digit blanks while every digit above it is zero.
        lz_blank = '0;
        zero_run = DISP_blank_lz;
        for (int k = 6; k >= 1; k--) begin
            zero_run    = zero_run & (nib[k] == 4'h0);
            lz_blank[k] = zero_run;
        end

        cur_cat = lz_blank[idx] ? 7'h7F : font(nib[idx]);
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            div     <= '0;
            idx     <= '0;
            sh      <= SYS_leds;
            ss      <= SYS_output_sel[3:0];
            SEG_an  <= 8'hFF;
            SEG_cat <= 7'h7F;
            SEG_dp  <= 1'b1;
        end else begin
            SEG_an  <= ~(8'b1 << idx);
            SEG_cat <= cur_cat;
            SEG_dp  <= (idx != 3'd7);
            if (div_last) begin
                div <= '0;
                idx <= idx + 3'd1;
                if (idx == 3'd7 && !DISP_hold) begin
                    sh <= SYS_leds;
                    ss <= SYS_output_sel[3:0];
                end
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule
